// File: rtl/memory_port_arbiter_if.sv
// memory_port_arbiter_if: fetch, data and backing-memory handshake signals shared by the arbiter and its clients
interface memory_port_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic              if_ack;
   logic [DATA_W-1:0] if_rdata;
   logic              dm_req;
   logic              dm_we;
   logic [ADDR_W-1:0] dm_addr;
   logic [DATA_W-1:0] dm_wdata;
   logic              dm_ack;
   logic [DATA_W-1:0] dm_rdata;
   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_ack;
   logic [DATA_W-1:0] mem_rdata;
   logic              stall_if;
   logic              stall_dm;
   logic [1:0]        owner;
   modport master (
      input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_ack, mem_rdata,
      output if_ack, if_rdata, dm_ack, dm_rdata, mem_req, mem_we, mem_addr, mem_wdata,
             stall_if, stall_dm, owner
   );
   modport slave (
      output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_ack, mem_rdata,
      input  if_ack, if_rdata, dm_ack, dm_rdata, mem_req, mem_we, mem_addr, mem_wdata,
             stall_if, stall_dm, owner
   );
endinterface

// File: rtl/memory_port_arbiter.sv
// memory_port_arbiter: shares one memory port between fetch and data stages; data wins unless fetch has starved
module memory_port_arbiter #(
   parameter int ADDR_W       = 32,
   parameter int DATA_W       = 32,
   parameter int STARVE_LIMIT = 4
) (
   input logic                   clock,
   input logic                   reset,
   memory_port_arbiter_if.master bus
);
   typedef enum logic [2:0] {IDLE, BUSY_IF, BUSY_DM, RESP_IF, RESP_DM} state_t;
   localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);
   state_t            state_q, state_d;
   logic [3:0]        starve_q, starve_d;
   logic              mem_req_q, mem_req_d, mem_we_q, mem_we_d;
   logic              if_ack_q, if_ack_d, dm_ack_q, dm_ack_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d, if_rdata_q, if_rdata_d, dm_rdata_q, dm_rdata_d;
   logic [1:0]        owner_q, owner_d;
   logic              fetch_wins;
   always_comb begin
      fetch_wins  = bus.if_req && (!bus.dm_req || starve_q >= LIMIT);
      state_d     = state_q;
      starve_d    = starve_q;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      if_rdata_d  = if_rdata_q;
      dm_rdata_d  = dm_rdata_q;
      owner_d     = owner_q;
      if_ack_d    = 1'b0;
      dm_ack_d    = 1'b0;
      case (state_q)
         IDLE: begin
            if (fetch_wins) begin
               state_d     = BUSY_IF;
               mem_req_d   = 1'b1;
               mem_we_d    = 1'b0;
               mem_addr_d  = bus.if_addr;
               mem_wdata_d = '0;
               owner_d     = 2'b01;
               starve_d    = '0;
            end else if (bus.dm_req) begin
               state_d     = BUSY_DM;
               mem_req_d   = 1'b1;
               mem_we_d    = bus.dm_we;
               mem_addr_d  = bus.dm_addr;
               mem_wdata_d = bus.dm_wdata;
               owner_d     = 2'b10;
               // count only data grants that made a waiting fetch lose
               starve_d    = !bus.if_req ? 4'd0 : (starve_q == 4'd15 ? starve_q : starve_q + 4'd1);
            end
         end
         BUSY_IF: if (bus.mem_ack) begin
            state_d    = RESP_IF;
            mem_req_d  = 1'b0;
            if_rdata_d = bus.mem_rdata;
            if_ack_d   = 1'b1;
         end
         BUSY_DM: if (bus.mem_ack) begin
            state_d    = RESP_DM;
            mem_req_d  = 1'b0;
            dm_rdata_d = mem_we_q ? '0 : bus.mem_rdata;
            dm_ack_d   = 1'b1;
         end
         default: begin
            state_d = IDLE;
            owner_d = 2'b00;
         end
      endcase
   end
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= IDLE;
         starve_q    <= '0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         if_ack_q    <= 1'b0;
         dm_ack_q    <= 1'b0;
         if_rdata_q  <= '0;
         dm_rdata_q  <= '0;
         owner_q     <= 2'b00;
      end else begin
         state_q     <= state_d;
         starve_q    <= starve_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         if_ack_q    <= if_ack_d;
         dm_ack_q    <= dm_ack_d;
         if_rdata_q  <= if_rdata_d;
         dm_rdata_q  <= dm_rdata_d;
         owner_q     <= owner_d;
      end
   end
   assign bus.mem_req   = mem_req_q;
   assign bus.mem_we    = mem_we_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = mem_wdata_q;
   assign bus.if_ack    = if_ack_q;
   assign bus.dm_ack    = dm_ack_q;
   assign bus.if_rdata  = if_rdata_q;
   assign bus.dm_rdata  = dm_rdata_q;
   assign bus.owner     = owner_q;
   assign bus.stall_if  = bus.if_req & ~if_ack_q;
   assign bus.stall_dm  = bus.dm_req & ~dm_ack_q;
endmodule

// File: tb/tb_memory_port_arbiter.sv
// tb_memory_port_arbiter: directed and randomized checks of the memory port arbiter against a transaction-level model
module tb_memory_port_arbiter;
   localparam int LIMIT = 4;
   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;
   memory_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();
   memory_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(LIMIT)) dut (
      .clock(clock), .reset(reset), .bus(bus)
   );
   typedef struct {
      logic [1:0]  owner;
      logic [31:0] addr;
      logic        we;
      logic [31:0] wdata;
      logic        pif, pdm;
      logic [31:0] if_a, dm_a;
      int          cyc;
   } grant_t;
   typedef struct {logic [31:0] data; int cyc;} ack_t;
   typedef struct {logic we; logic [31:0] addr; logic [31:0] wdata;} dreq_t;
   int n_checks = 0, n_fail = 0, cyc = 0;
   int stab_err = 0, stall_err = 0, req_cycles = 0, mem_ack_cyc = 0;
   bit mem_auto = 1, mem_rand = 0, if_agent = 0, dm_agent = 0, no_gap = 1;
   int mem_delay = 0, mem_cnt = 0;
   logic prev_req = 1'b0;
   logic [66:0] prev_bus = '0;
   logic [31:0] mem_arr [logic [31:0]];
   grant_t grants[$];
   ack_t if_acks[$], dm_acks[$];
   logic [31:0] if_q[$], if_exp[$], dm_exp[$];
   dreq_t dm_q[$];
   function automatic logic [31:0] rd(logic [31:0] a);
      return mem_arr.exists(a) ? mem_arr[a] : {~a[15:0], a[15:0]};
   endfunction
   task automatic clear_logs();
      grants.delete(); if_acks.delete(); dm_acks.delete(); if_exp.delete(); dm_exp.delete();
      stab_err = 0; stall_err = 0; req_cycles = 0;
   endtask
   // one clock: observe outputs, then play memory and requesters for the next cycle
   task automatic tick();
      logic pif, pdm;
      grant_t g;
      ack_t a;
      dreq_t d;
      pif = bus.if_req;
      pdm = bus.dm_req;
      @(negedge clock);
      cyc++;
      if (bus.stall_if !== (bus.if_req & ~bus.if_ack) || bus.stall_dm !== (bus.dm_req & ~bus.dm_ack)) stall_err++;
      if (bus.mem_req === 1'b1 && prev_req !== 1'b1) begin
         g.owner = bus.owner; g.addr = bus.mem_addr; g.we = bus.mem_we; g.wdata = bus.mem_wdata;
         g.pif = pif; g.pdm = pdm; g.if_a = bus.if_addr; g.dm_a = bus.dm_addr; g.cyc = cyc;
         grants.push_back(g);
      end
      if (bus.mem_req === 1'b1 && prev_req === 1'b1 && {bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.owner} !== prev_bus) stab_err++;
      if (bus.mem_req === 1'b1) req_cycles++;
      if (bus.if_ack === 1'b1) begin a.data = bus.if_rdata; a.cyc = cyc; if_acks.push_back(a); end
      if (bus.dm_ack === 1'b1) begin a.data = bus.dm_rdata; a.cyc = cyc; dm_acks.push_back(a); end
      prev_req = bus.mem_req;
      prev_bus = {bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.owner};
      if (mem_auto) begin
         if (bus.mem_req === 1'b1 && bus.mem_ack !== 1'b1) begin
            if (mem_cnt == 0 && mem_rand) mem_delay = int'($urandom_range(3));
            mem_cnt++;
            if (mem_cnt > mem_delay) begin
               bus.mem_ack = 1'b1;
               mem_ack_cyc = cyc;
               bus.mem_rdata = bus.mem_we ? $urandom : rd(bus.mem_addr);
               if (bus.mem_we) mem_arr[bus.mem_addr] = bus.mem_wdata;
            end
         end else begin
            bus.mem_ack = 1'b0;
            mem_cnt = 0;
         end
      end
      if (if_agent) begin
         if (bus.if_req && bus.if_ack) bus.if_req = 1'b0;
         if (!bus.if_req && if_q.size() > 0 && (no_gap || $urandom_range(2) != 0)) begin
            bus.if_addr = if_q.pop_front();
            if_exp.push_back(rd(bus.if_addr));
            bus.if_req = 1'b1;
         end
      end
      if (dm_agent) begin
         if (bus.dm_req && bus.dm_ack) bus.dm_req = 1'b0;
         if (!bus.dm_req && dm_q.size() > 0 && (no_gap || $urandom_range(2) != 0)) begin
            d = dm_q.pop_front();
            bus.dm_we = d.we; bus.dm_addr = d.addr; bus.dm_wdata = d.wdata;
            dm_exp.push_back(d.we ? 32'h0 : rd(d.addr));
            bus.dm_req = 1'b1;
         end
      end
   endtask
   task automatic test_reset();
      reset = 1'b1;
      repeat (3) tick();
      n_checks++; if (bus.mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_mem_req: got %b want 0", bus.mem_req); end
      n_checks++; if (bus.mem_we !== 1'b0) begin n_fail++; $display("FAIL reset_mem_we: got %b want 0", bus.mem_we); end
      n_checks++; if (bus.mem_addr !== 32'h0) begin n_fail++; $display("FAIL reset_mem_addr: got %h want 0", bus.mem_addr); end
      n_checks++; if (bus.mem_wdata !== 32'h0) begin n_fail++; $display("FAIL reset_mem_wdata: got %h want 0", bus.mem_wdata); end
      n_checks++; if ({bus.if_ack, bus.dm_ack} !== 2'b00) begin n_fail++; $display("FAIL reset_acks: got %b want 00", {bus.if_ack, bus.dm_ack}); end
      n_checks++; if (bus.if_rdata !== 32'h0 || bus.dm_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h/%h want 0/0", bus.if_rdata, bus.dm_rdata); end
      n_checks++; if (bus.owner !== 2'b00) begin n_fail++; $display("FAIL reset_owner: got %b want 00", bus.owner); end
      n_checks++; if ({bus.stall_if, bus.stall_dm} !== 2'b00) begin n_fail++; $display("FAIL reset_stalls: got %b want 00", {bus.stall_if, bus.stall_dm}); end
      reset = 1'b0;
   endtask
   task automatic test_fetch_only();
      int c0, n;
      logic [7:0] stall_seen;
      clear_logs(); mem_delay = 1; mem_arr[32'h10] = 32'hA1B2C3D4;
      bus.if_addr = 32'h10; bus.if_req = 1'b1;
      #1;
      c0 = cyc;
      stall_seen = '0;
      stall_seen[0] = bus.stall_if;
      n = 0;
      while (if_acks.size() == 0 && n < 20) begin
         tick(); n++;
         if (cyc - c0 < 8) stall_seen[cyc - c0] = bus.stall_if;
      end
      bus.if_req = 1'b0;
      repeat (4) tick();
      n_checks++; if (if_acks.size() !== 1) begin n_fail++; $display("FAIL fetch_ack_count: got %0d want 1", if_acks.size()); end
      else begin
         n_checks++; if (if_acks[0].cyc - c0 !== 3) begin n_fail++; $display("FAIL fetch_ack_cycle: got %0d want 3", if_acks[0].cyc - c0); end
         n_checks++; if (if_acks[0].data !== 32'hA1B2C3D4) begin n_fail++; $display("FAIL fetch_rdata: got %h want a1b2c3d4", if_acks[0].data); end
         n_checks++; if (stall_seen[3:0] !== 4'b0111) begin n_fail++; $display("FAIL fetch_stall_window: got %b want 0111", stall_seen[3:0]); end
      end
      n_checks++; if (grants.size() !== 1) begin n_fail++; $display("FAIL fetch_grant_count: got %0d want 1", grants.size()); end
      else begin
         n_checks++; if ({grants[0].owner, grants[0].we, grants[0].addr} !== {2'b01, 1'b0, 32'h10}) begin n_fail++; $display("FAIL fetch_grant: got owner %b we %b addr %h want 01 0 10", grants[0].owner, grants[0].we, grants[0].addr); end
      end
   endtask
   task automatic test_contention();
      int n, stall_bad;
      clear_logs(); mem_delay = 0; stall_bad = 0;
      bus.if_addr = 32'h20; bus.if_req = 1'b1;
      bus.dm_we = 1'b1; bus.dm_addr = 32'h100; bus.dm_wdata = 32'hDEADBEEF; bus.dm_req = 1'b1;
      n = 0;
      while ((bus.if_req || bus.dm_req) && n < 40) begin
         tick(); n++;
         if (bus.if_req && !bus.if_ack && bus.stall_if !== 1'b1) stall_bad++;
         if (bus.dm_ack) bus.dm_req = 1'b0;
         if (bus.if_ack) bus.if_req = 1'b0;
      end
      repeat (3) tick();
      n_checks++; if (grants.size() !== 2 || dm_acks.size() !== 1 || if_acks.size() !== 1) begin n_fail++; $display("FAIL contention_counts: grants %0d dm_acks %0d if_acks %0d want 2 1 1", grants.size(), dm_acks.size(), if_acks.size()); end
      else begin
         n_checks++; if ({grants[0].owner, grants[0].we, grants[0].addr, grants[0].wdata} !== {2'b10, 1'b1, 32'h100, 32'hDEADBEEF}) begin n_fail++; $display("FAIL contention_first_grant: got %b %b %h %h want 10 1 100 deadbeef", grants[0].owner, grants[0].we, grants[0].addr, grants[0].wdata); end
         n_checks++; if (dm_acks[0].data !== 32'h0) begin n_fail++; $display("FAIL contention_write_rdata: got %h want 0", dm_acks[0].data); end
         n_checks++; if ({grants[1].owner, grants[1].we, grants[1].addr, grants[1].wdata} !== {2'b01, 1'b0, 32'h20, 32'h0}) begin n_fail++; $display("FAIL contention_second_grant: got %b %b %h %h want 01 0 20 0", grants[1].owner, grants[1].we, grants[1].addr, grants[1].wdata); end
         n_checks++; if (grants[1].cyc !== dm_acks[0].cyc + 2) begin n_fail++; $display("FAIL contention_regrant_cycle: got %0d want %0d", grants[1].cyc, dm_acks[0].cyc + 2); end
      end
      n_checks++; if (rd(32'h100) !== 32'hDEADBEEF) begin n_fail++; $display("FAIL contention_mem_write: got %h want deadbeef", rd(32'h100)); end
      n_checks++; if (stall_bad !== 0 || stall_err !== 0) begin n_fail++; $display("FAIL contention_stall: got %0d/%0d bad cycles want 0", stall_bad, stall_err); end
   endtask
   task automatic test_starvation();
      int n;
      int ack_c[$];
      logic [1:0] want [8] = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b10, 2'b10, 2'b01};
      clear_logs(); mem_delay = 0; no_gap = 1;
      if_q = '{32'h30, 32'h34};
      for (int i = 0; i < 6; i++) dm_q.push_back('{1'b0, 32'h80 + 32'(4 * i), 32'h0});
      if_agent = 1; dm_agent = 1;
      n = 0;
      while ((if_acks.size() < 2 || dm_acks.size() < 6) && n < 300) begin tick(); n++; end
      if_agent = 0; dm_agent = 0;
      bus.if_req = 1'b0; bus.dm_req = 1'b0;
      repeat (3) tick();
      n_checks++; if (grants.size() !== 8) begin n_fail++; $display("FAIL starve_grant_count: got %0d want 8", grants.size()); end
      else begin
         foreach (if_acks[i]) ack_c.push_back(if_acks[i].cyc);
         foreach (dm_acks[i]) ack_c.push_back(dm_acks[i].cyc);
         ack_c.sort();
         for (int i = 0; i < 8; i++) begin
            n_checks++; if (grants[i].owner !== want[i]) begin n_fail++; $display("FAIL starve_owner_%0d: got %b want %b", i, grants[i].owner, want[i]); end
            if (i > 0 && ack_c.size() >= i) begin
               n_checks++; if (grants[i].cyc !== ack_c[i - 1] + 2) begin n_fail++; $display("FAIL starve_spacing_%0d: got %0d want %0d", i, grants[i].cyc, ack_c[i - 1] + 2); end
            end
         end
         n_checks++; if (grants[4].addr !== 32'h30 || grants[7].addr !== 32'h34) begin n_fail++; $display("FAIL starve_fetch_addr: got %h/%h want 30/34", grants[4].addr, grants[7].addr); end
      end
   endtask
   task automatic test_wait_states();
      int n;
      clear_logs(); mem_delay = 6; mem_arr[32'h40] = 32'h12345678;
      bus.dm_we = 1'b0; bus.dm_addr = 32'h40; bus.dm_wdata = 32'h0; bus.dm_req = 1'b1;
      n = 0;
      while (dm_acks.size() == 0 && n < 40) begin tick(); n++; end
      bus.dm_req = 1'b0;
      repeat (4) tick();
      mem_delay = 0;
      n_checks++; if (dm_acks.size() !== 1) begin n_fail++; $display("FAIL wait_ack_count: got %0d want 1", dm_acks.size()); end
      else begin
         n_checks++; if (dm_acks[0].cyc !== mem_ack_cyc + 1) begin n_fail++; $display("FAIL wait_ack_cycle: got %0d want %0d", dm_acks[0].cyc, mem_ack_cyc + 1); end
         n_checks++; if (dm_acks[0].data !== 32'h12345678) begin n_fail++; $display("FAIL wait_rdata: got %h want 12345678", dm_acks[0].data); end
      end
      n_checks++; if (req_cycles !== 7) begin n_fail++; $display("FAIL wait_req_cycles: got %0d want 7", req_cycles); end
      n_checks++; if (stab_err !== 0) begin n_fail++; $display("FAIL wait_stability: got %0d changes want 0", stab_err); end
      n_checks++; if (grants.size() !== 1 || grants[0].addr !== 32'h40) begin n_fail++; $display("FAIL wait_grants: got %0d grants want 1 at 40", grants.size()); end
   endtask
   task automatic test_reset_mid();
      int n;
      clear_logs(); mem_auto = 0; bus.mem_ack = 1'b0;
      bus.if_addr = 32'h50; bus.if_req = 1'b1;
      n = 0;
      while (bus.mem_req !== 1'b1 && n < 10) begin tick(); n++; end
      n_checks++; if (bus.mem_req !== 1'b1) begin n_fail++; $display("FAIL rstmid_grant: got mem_req %b want 1", bus.mem_req); end
      tick();
      reset = 1'b1; bus.if_req = 1'b0;
      tick();
      n_checks++; if ({bus.mem_req, bus.mem_we, bus.if_ack, bus.dm_ack, bus.owner} !== 6'b0) begin n_fail++; $display("FAIL rstmid_ctrl: got %b want 000000", {bus.mem_req, bus.mem_we, bus.if_ack, bus.dm_ack, bus.owner}); end
      n_checks++; if ({bus.mem_addr, bus.mem_wdata, bus.if_rdata, bus.dm_rdata} !== 128'h0) begin n_fail++; $display("FAIL rstmid_data: got %h %h %h %h want 0", bus.mem_addr, bus.mem_wdata, bus.if_rdata, bus.dm_rdata); end
      reset = 1'b0;
      bus.mem_rdata = 32'hBAD0BAD0; bus.mem_ack = 1'b1;
      tick();
      bus.mem_ack = 1'b0;
      repeat (4) tick();
      n_checks++; if (if_acks.size() !== 0 || grants.size() !== 1) begin n_fail++; $display("FAIL rstmid_late_ack: got %0d acks %0d grants want 0 1", if_acks.size(), grants.size()); end
      mem_auto = 1; mem_delay = 0;
      bus.if_addr = 32'h54; bus.if_req = 1'b1;
      n = 0;
      while (if_acks.size() == 0 && n < 20) begin tick(); n++; end
      bus.if_req = 1'b0;
      repeat (3) tick();
      n_checks++; if (if_acks.size() !== 1 || grants.size() !== 2) begin n_fail++; $display("FAIL rstmid_recover: got %0d acks %0d grants want 1 2", if_acks.size(), grants.size()); end
      else begin
         n_checks++; if (if_acks[0].data !== rd(32'h54) || grants[1].addr !== 32'h54) begin n_fail++; $display("FAIL rstmid_recover_data: got %h at %h want %h at 54", if_acks[0].data, grants[1].addr, rd(32'h54)); end
      end
   endtask
   task automatic test_hold_through_ack();
      int n;
      clear_logs(); mem_delay = 0;
      bus.if_addr = 32'h60; bus.if_req = 1'b1;
      n = 0;
      while (if_acks.size() == 0 && n < 20) begin tick(); n++; end
      tick();
      bus.if_req = 1'b0;
      repeat (5) tick();
      n_checks++; if (grants.size() !== 1 || if_acks.size() !== 1) begin n_fail++; $display("FAIL hold_no_regrant: got %0d grants %0d acks want 1 1", grants.size(), if_acks.size()); end
      clear_logs();
      bus.dm_we = 1'b0; bus.dm_addr = 32'h70; bus.dm_req = 1'b1;
      n = 0;
      while (dm_acks.size() == 0 && n < 20) begin tick(); n++; end
      repeat (2) tick();
      bus.dm_req = 1'b0;
      repeat (6) tick();
      n_checks++; if (grants.size() !== 2 || dm_acks.size() !== 2) begin n_fail++; $display("FAIL hold_regrant_count: got %0d grants %0d acks want 2 2", grants.size(), dm_acks.size()); end
      else begin
         n_checks++; if (grants[1].cyc !== dm_acks[0].cyc + 2) begin n_fail++; $display("FAIL hold_regrant_cycle: got %0d want %0d", grants[1].cyc, dm_acks[0].cyc + 2); end
      end
   endtask
   task automatic test_random();
      int n, starve, n_if, n_dm;
      logic [1:0] want;
      dreq_t d;
      dreq_t wr[$];
      clear_logs(); mem_rand = 1; no_gap = 0; n_if = 30; n_dm = 30;
      for (int i = 0; i < n_if; i++) if_q.push_back(32'h1000 + 32'(4 * i));
      for (int i = 0; i < n_dm; i++) begin
         d.we = 1'($urandom_range(1));
         d.addr = d.we ? 32'h3000 + 32'(4 * i) : 32'h2000 + 32'(4 * $urandom_range(63));
         d.wdata = $urandom;
         if (d.we) wr.push_back(d);
         dm_q.push_back(d);
      end
      if_agent = 1; dm_agent = 1;
      n = 0;
      while ((if_acks.size() < n_if || dm_acks.size() < n_dm) && n < 3000) begin tick(); n++; end
      if_agent = 0; dm_agent = 0; mem_rand = 0; mem_delay = 0; no_gap = 1;
      bus.if_req = 1'b0; bus.dm_req = 1'b0;
      repeat (4) tick();
      n_checks++; if (if_acks.size() !== n_if || dm_acks.size() !== n_dm || grants.size() !== n_if + n_dm) begin n_fail++; $display("FAIL rand_counts: got %0d/%0d acks %0d grants want %0d/%0d %0d", if_acks.size(), dm_acks.size(), grants.size(), n_if, n_dm, n_if + n_dm); end
      foreach (if_acks[i]) if (i < if_exp.size()) begin
         n_checks++; if (if_acks[i].data !== if_exp[i]) begin n_fail++; $display("FAIL rand_if_rdata_%0d: got %h want %h", i, if_acks[i].data, if_exp[i]); end
      end
      foreach (dm_acks[i]) if (i < dm_exp.size()) begin
         n_checks++; if (dm_acks[i].data !== dm_exp[i]) begin n_fail++; $display("FAIL rand_dm_rdata_%0d: got %h want %h", i, dm_acks[i].data, dm_exp[i]); end
      end
      starve = 0;
      foreach (grants[i]) begin
         want = (grants[i].pdm && !(grants[i].pif && starve >= LIMIT)) ? 2'b10 : 2'b01;
         starve = want == 2'b01 ? 0 : (grants[i].pif ? (starve < 15 ? starve + 1 : 15) : 0);
         n_checks++; if (grants[i].owner !== want || grants[i].addr !== (want == 2'b01 ? grants[i].if_a : grants[i].dm_a)) begin n_fail++; $display("FAIL rand_grant_%0d: got owner %b addr %h want owner %b", i, grants[i].owner, grants[i].addr, want); end
      end
      foreach (wr[i]) begin
         n_checks++; if (rd(wr[i].addr) !== wr[i].wdata) begin n_fail++; $display("FAIL rand_write_%0d: got %h want %h at %h", i, rd(wr[i].addr), wr[i].wdata, wr[i].addr); end
      end
      n_checks++; if (stab_err !== 0 || stall_err !== 0) begin n_fail++; $display("FAIL rand_stability_stall: got %0d/%0d want 0/0", stab_err, stall_err); end
   endtask
   initial begin
      bus.if_req = 1'b0; bus.if_addr = '0; bus.dm_req = 1'b0; bus.dm_we = 1'b0;
      bus.dm_addr = '0; bus.dm_wdata = '0; bus.mem_ack = 1'b0; bus.mem_rdata = '0;
      test_reset();
      test_fetch_only();
      test_contention();
      test_starvation();
      test_wait_states();
      test_reset_mid();
      test_hold_through_ack();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
